fft_result_buffer: RTL

- Downstream neighbour of the 32-point FFT top. Consumes its serial signed 17-bit result stream, qualified per word by the FFT's finish output.
- Captures one complete frame into an internal buffer, then replays it to a host with a valid/ready handshake.
- Flags frames that arrive while the buffer is still occupied.
- Optionally tracks the largest-magnitude word of each frame.

---
 rtl/fft_result_buffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fft_result_buffer.sv
// Frame capture buffer behind the 32-point FFT: collects one serial result frame, replays it over valid/ready.
// Optional largest-magnitude tracking is enabled with FFT_RESULT_BUFFER_PEAK_EN.
module fft_result_buffer #(
  parameter int DATA_W    = 17,
  parameter int FRAME_LEN = 32,
  parameter int IDX_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              frame_ready,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [IDX_W-1:0]  peak_idx,
  output logic [DATA_W-1:0] peak_val
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  state_t            state, state_nx;
  logic [DATA_W-1:0] mem [FRAME_LEN];
  logic [IDX_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nx;
  logic              wr_en, last_wr, accept;

  assign wr_en     = in_valid && ((state == IDLE) || (state == FILL));
  assign last_wr   = in_valid && (state == FILL) && (wr_ptr == LAST);
  assign accept    = out_valid && out_ready;
  assign rd_ptr_nx = rd_ptr + 1'b1;
  assign out_idx   = rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    out_valid   = 1'b0;
    frame_ready = 1'b0;
    case (state)
      IDLE: if (in_valid) state_nx = FILL;
      FILL: if (last_wr) state_nx = HOLD;
      HOLD: begin
        out_valid   = 1'b1;
        frame_ready = 1'b1;
        if (out_ready) state_nx = out_last ? IDLE : DRAIN;
      end
      DRAIN: begin
        out_valid   = 1'b1;
        frame_ready = 1'b1;
        if (out_ready && out_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  // The output register always holds the word at rd_ptr, so each accept loads rd_ptr+1 directly from the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= last_wr ? '0 : wr_ptr + 1'b1;
      if (last_wr) begin
        out_data <= mem[0];
        rd_ptr   <= '0;
        out_last <= 1'b0;
      end else if (accept) begin
        if (out_last) begin
          out_data <= '0;
          rd_ptr   <= '0;
          out_last <= 1'b0;
        end else begin
          out_data <= mem[rd_ptr_nx];
          rd_ptr   <= rd_ptr_nx;
          out_last <= (rd_ptr_nx == LAST);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       overrun <= 1'b0;
    else if (in_valid && out_valid) overrun <= 1'b1;
    else if (overrun_clr)          overrun <= 1'b0;
  end

`ifdef FFT_RESULT_BUFFER_PEAK_EN
  logic [DATA_W-1:0] mag, run_max;
  logic [IDX_W-1:0]  run_idx;
  logic              bigger;

  always_comb begin
    mag = in_data;
    if (in_data == {1'b1, {(DATA_W-1){1'b0}}}) mag = {1'b0, {(DATA_W-1){1'b1}}};
    else if (in_data[DATA_W-1])                mag = -in_data;
  end

  assign bigger = mag > run_max;

  // Strict compare keeps the lowest index on ties; the frame's first write seeds the running max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max  <= '0;
      run_idx  <= '0;
      peak_idx <= '0;
      peak_val <= '0;
    end else if (wr_en) begin
      if (state == IDLE) begin
        run_max <= mag;
        run_idx <= '0;
      end else if (bigger) begin
        run_max <= mag;
        run_idx <= wr_ptr;
      end
      if (last_wr) begin
        peak_val <= bigger ? mag : run_max;
        peak_idx <= bigger ? wr_ptr : run_idx;
      end
    end
  end
`else
  assign peak_idx = '0;
  assign peak_val = '0;
`endif

endmodule
